// File: rtl/design1_wrapper.sv
// FSIC system wrapper: peripheral reset sequencer, Caravel boot/status emulation
// and a 64 KB AXI4-Lite register window driving the user-project I/O bus.
module design1_wrapper #(
    parameter logic [31:0] BASE_ADDR       = 32'h6000_0000,
    parameter int          RST_HOLD_CYCLES = 16,
    parameter int          BOOT_CYCLES     = 1024
) (
    input  logic        sys_clock,
    input  logic        sys_reset,
    input  logic        resetb_0,
    output logic        periph_aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [37:0] mprj_o
);
    // Boot FSM states
    //   state    | meaning
    //   ST_RESET | core held: peripheral reset active or resetb_0 low
    //   ST_BOOT  | firmware boot timer running
    //   ST_READY | firmware ready, mprj_o[37:36] = 2'b11
    typedef enum logic [1:0] {ST_RESET, ST_BOOT, ST_READY} state_e;

    localparam int          RW       = $clog2(RST_HOLD_CYCLES + 1);
    localparam int          BW       = $clog2(BOOT_CYCLES + 1);
    localparam logic [13:0] OFF_CTRL = 14'h1C00;
    localparam logic [13:0] OFF_DATA = 14'h1400;
    localparam logic [1:0]  RESP_OK  = 2'b00;
    localparam logic [1:0]  RESP_DEC = 2'b11;

    logic [RW-1:0] hold_cnt_q;
    logic          periph_q;
    logic          rstb_meta_q, rstb_sync_q;
    state_e        state_q, state_d;
    logic [BW-1:0] boot_cnt_q;
    logic [1:0]    boot_status;

    logic          aw_done_q, w_done_q, bvalid_q;
    logic [31:2]   awaddr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [1:0]    bresp_q;
    logic [1:0]    ctrl_q;
    logic [31:0]   data_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q, rd_data;
    logic [1:0]    rresp_q, rd_resp;
    logic          aw_hs, w_hs, ar_hs, wr_in_win, rd_in_win;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            hold_cnt_q <= RW'(RST_HOLD_CYCLES);
            periph_q   <= 1'b0;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - RW'(1);
        end else begin
            periph_q   <= 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            rstb_meta_q <= 1'b0;
            rstb_sync_q <= 1'b0;
        end else begin
            rstb_meta_q <= resetb_0;
            rstb_sync_q <= rstb_meta_q;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) state_q <= ST_RESET;
        else           state_q <= state_d;
    end

    // Timer reloads every cycle spent in ST_RESET, so BOOT always sees a full count.
    always_ff @(posedge sys_clock) begin
        if (sys_reset)                                boot_cnt_q <= '0;
        else if (state_q == ST_RESET)                 boot_cnt_q <= BW'(BOOT_CYCLES - 1);
        else if (state_q == ST_BOOT && boot_cnt_q != '0) boot_cnt_q <= boot_cnt_q - BW'(1);
    end

    always_comb begin
        state_d = state_q;
        if (!periph_q || !rstb_sync_q) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_BOOT;
                ST_BOOT:  if (boot_cnt_q == '0) state_d = ST_READY;
                ST_READY: state_d = ST_READY;
                default:  state_d = ST_RESET;
            endcase
        end
    end

    always_comb begin
        boot_status = 2'b00;
        if (state_q == ST_READY) boot_status = 2'b11;
    end

    assign s_axi_awready = periph_q & ~aw_done_q & ~bvalid_q;
    assign s_axi_wready  = periph_q & ~w_done_q & ~bvalid_q;
    assign s_axi_bvalid  = periph_q & bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign w_hs          = s_axi_wvalid & s_axi_wready;
    assign wr_in_win     = (awaddr_q[31:16] == BASE_ADDR[31:16]);

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OK;
            ctrl_q    <= '0;
            data_q    <= '0;
        end else begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
                awaddr_q  <= s_axi_awaddr[31:2];
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end
            if (aw_done_q && w_done_q) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_win ? RESP_OK : RESP_DEC;
                if (wr_in_win && awaddr_q[15:2] == OFF_CTRL && wstrb_q[0]) ctrl_q <= wdata_q[1:0];
                if (wr_in_win && awaddr_q[15:2] == OFF_DATA) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wstrb_q[i]) data_q[8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_arready = periph_q & ~rvalid_q;
    assign s_axi_rvalid  = periph_q & rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign rd_in_win     = (s_axi_araddr[31:16] == BASE_ADDR[31:16]);

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OK;
        if (!rd_in_win)                          rd_resp = RESP_DEC;
        else if (s_axi_araddr[15:2] == OFF_CTRL) rd_data = {30'b0, ctrl_q};
        else if (s_axi_araddr[15:2] == OFF_DATA) rd_data = data_q;
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OK;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign periph_aresetn = periph_q;
    assign mprj_o         = {boot_status, 26'b0, data_q[7:0], ctrl_q};

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for design1_wrapper: reset/boot timing, register access, decode
// and handshake ordering, with expected AXI responses kept in scoreboard queues.
module tb_design1_wrapper;
    localparam logic [31:0] A_CTRL = 32'h6000_7000;
    localparam logic [31:0] A_DATA = 32'h6000_5000;
    localparam logic [31:0] A_OUT  = 32'h7000_0000;
    localparam logic [31:0] A_UNM  = 32'h6000_1234;
    localparam logic [1:0]  OK     = 2'b00;
    localparam logic [1:0]  DEC    = 2'b11;

    logic        sys_clock = 1'b0;
    logic        sys_reset, resetb_0, periph_aresetn;
    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [37:0] mprj_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic [1:0]  exp_bresp_q[$];

    always #5 sys_clock = ~sys_clock;

    design1_wrapper dut (
        .sys_clock(sys_clock), .sys_reset(sys_reset), .resetb_0(resetb_0),
        .periph_aresetn(periph_aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .mprj_o(mprj_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic reset_sequence();
        int n = 0;
        sys_reset = 1'b1;
        repeat (50) step();
        chk("rst_periph", periph_aresetn, 0);
        chk("rst_mprj", mprj_o, 0);
        chk("rst_handshakes", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 0);
        sys_reset = 1'b0;
        while (!periph_aresetn && n < 100) begin
            step();
            n++;
        end
        chk("periph_release_latency", n, 17);
        chk("mprj_after_release", mprj_o, 0);
    endtask

    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead);
        int cyc = 0;
        bit aw_pend = 1'b1, w_pend = 1'b1, hs_aw, hs_w;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        s_axi_awvalid = (w_lead == 0);
        while ((aw_pend || w_pend) && cyc < 50) begin
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            step();
            cyc++;
            if (hs_aw) begin s_axi_awvalid = 1'b0; aw_pend = 1'b0; end
            if (hs_w)  begin s_axi_wvalid  = 1'b0; w_pend  = 1'b0; end
            if (aw_pend && !s_axi_awvalid && cyc >= w_lead) s_axi_awvalid = 1'b1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("aw_w_accepted", {aw_pend, w_pend}, 2'b00);
    endtask

    task automatic wait_b(input int b_delay);
        int cyc = 0;
        bit stable = 1'b1;
        logic [1:0] first, exp;
        while (!s_axi_bvalid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("bvalid_rise", s_axi_bvalid, 1);
        first = s_axi_bresp;
        for (int i = 0; i < b_delay; i++) begin
            step();
            if (!(s_axi_bvalid === 1'b1 && s_axi_bresp === first)) stable = 1'b0;
        end
        if (b_delay > 0) chk("bvalid_held", stable, 1);
        s_axi_bready = 1'b1;
        exp = (exp_bresp_q.size() != 0) ? exp_bresp_q.pop_front() : 2'bxx;
        chk("bresp", s_axi_bresp, exp);
        step();
        s_axi_bready = 1'b0;
        chk("bvalid_drop", s_axi_bvalid, 0);
    endtask

    task automatic send_ar(input logic [31:0] addr);
        int cyc = 0;
        bit hs = 1'b0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!hs && cyc < 20) begin
            hs = s_axi_arvalid && s_axi_arready;
            step();
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        chk("ar_accepted", hs, 1);
    endtask

    task automatic wait_r();
        int cyc = 0;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        while (!s_axi_rvalid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("rvalid_rise", s_axi_rvalid, 1);
        s_axi_rready = 1'b1;
        exp_d = (exp_rdata_q.size() != 0) ? exp_rdata_q.pop_front() : 32'hxxxx_xxxx;
        exp_r = (exp_rresp_q.size() != 0) ? exp_rresp_q.pop_front() : 2'bxx;
        chk("rdata", s_axi_rdata, exp_d);
        chk("rresp", s_axi_rresp, exp_r);
        step();
        s_axi_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        exp_bresp_q.push_back(resp);
        send_aw_w(addr, data, strb, 0);
        wait_b(0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        exp_rdata_q.push_back(data);
        exp_rresp_q.push_back(resp);
        send_ar(addr);
        wait_r();
    endtask

    initial begin
        int n;
        sys_reset = 1'b1; resetb_0 = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

        reset_sequence();

        axi_read(A_CTRL, 32'h0, OK);
        axi_write(A_CTRL, 32'h1, 4'hF, OK);
        axi_read(A_CTRL, 32'h1, OK);
        chk("mprj_ctrl_01", mprj_o[1:0], 2'b01);
        axi_write(A_CTRL, 32'h3, 4'hF, OK);
        axi_read(A_CTRL, 32'h3, OK);
        axi_write(A_CTRL, 32'hFFFF_FFFF, 4'hF, OK);
        axi_read(A_CTRL, 32'h3, OK);

        axi_read(A_DATA, 32'h0, OK);
        axi_write(A_DATA, 32'h11, 4'hF, OK);
        axi_read(A_DATA, 32'h11, OK);
        chk("mprj_data_11", mprj_o[9:2], 8'h11);
        axi_write(A_DATA, 32'hAABB_CCDD, 4'b0100, OK);
        axi_read(A_DATA, 32'h00BB_0011, OK);

        axi_read(A_OUT, 32'h0, DEC);
        axi_write(A_OUT, 32'hFFFF_FFFF, 4'hF, DEC);
        axi_write(A_UNM, 32'hFFFF_FFFF, 4'hF, OK);
        axi_read(A_UNM, 32'h0, OK);
        axi_read(A_CTRL, 32'h3, OK);
        axi_read(A_DATA, 32'h00BB_0011, OK);

        // W leads AW by three cycles, response held off for five
        exp_bresp_q.push_back(OK);
        send_aw_w(A_DATA, 32'h5A5A_5A5A, 4'hF, 3);
        wait_b(5);
        axi_read(A_DATA, 32'h5A5A_5A5A, OK);

        axi_write(A_CTRL, 32'h0, 4'hF, OK);
        exp_rdata_q.push_back(32'h0);
        exp_rresp_q.push_back(OK);
        exp_bresp_q.push_back(OK);
        s_axi_awaddr = A_CTRL; s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF;
        s_axi_araddr = A_CTRL;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        chk("same_cycle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        wait_r();
        wait_b(0);
        axi_read(A_CTRL, 32'h2, OK);

        resetb_0 = 1'b1;
        n = 0;
        while (mprj_o[37:36] !== 2'b11 && n < 2000) begin
            step();
            n++;
        end
        chk("boot_latency", n, 1027);
        chk("mprj_ready_full", mprj_o, {2'b11, 26'b0, 8'h5A, 2'b10});
        resetb_0 = 1'b0;
        n = 0;
        while (mprj_o[37:36] !== 2'b00 && n < 10) begin
            step();
            n++;
        end
        chk("boot_drop_within_3", (n <= 3), 1);
        chk("periph_after_core_reset", periph_aresetn, 1);
        axi_read(A_CTRL, 32'h2, OK);

        send_aw_w(A_CTRL, 32'h1, 4'hF, 0);
        step();
        chk("midtx_bvalid_pending", s_axi_bvalid, 1);
        sys_reset = 1'b1;
        step();
        chk("midtx_handshakes_dropped",
            {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 0);
        chk("midtx_mprj_cleared", mprj_o, 0);
        reset_sequence();
        axi_read(A_CTRL, 32'h0, OK);
        axi_read(A_DATA, 32'h0, OK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/design1_wrapper.md
# design1_wrapper

Top-level FSIC system wrapper: reset sequencer, Caravel boot/status emulation and an AXI4-Lite register window at 0x6000_0000. It takes the board clock and reset plus the Caravel core reset, exposes one AXI4-Lite slave port for the host/VIP, and drives the 38-bit Caravel user-project I/O bus (mprj_o). Firmware readiness is signalled on mprj_o[37:36].

## Interface
- BASE_ADDR, 32'h6000_0000, base of the 64 KB register window
- RST_HOLD_CYCLES, 16, cycles peripheral reset stays asserted after sys_reset deasserts
- BOOT_CYCLES, 1024, cycles from core reset release to firmware-ready

Ports:
- sys_clock  in  1  single system clock; all logic on rising edge
- sys_reset  in  1  synchronous, active-high system reset
- resetb_0  in  1  Caravel core reset, active-low, asynchronous source; 2-flop synchronized
- periph_aresetn  out  1  peripheral reset, active-low
- s_axi_awaddr / s_axi_araddr  in  32  write/read address
- s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready  in  1  AXI4-Lite handshakes
- s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid  out  1  AXI4-Lite handshakes
- s_axi_wdata  in  32  write data; s_axi_wstrb  in  4  byte strobes
- s_axi_bresp / s_axi_rresp  out  2  response (00 OKAY, 11 DECERR)
- s_axi_rdata  out  32  read data
- mprj_o  out  38  Caravel user I/O

## Operation
- Reset sequencer: sys_reset=1 clears everything; periph_aresetn=0. After sys_reset falls, counter runs RST_HOLD_CYCLES, then periph_aresetn=1.
- Boot FSM: states RESET -> BOOT -> READY.
  - RESET: stays while periph_aresetn=0 or synchronized resetb_0=0.
  - BOOT: counts BOOT_CYCLES.
  - READY: drives mprj_o[37:36]=2'b11.
  - Synchronized resetb_0=0 in any state returns to RESET and clears mprj_o[37:36] the next cycle.
- Registers, reset value 0, cleared by sys_reset only:
  - CTRL at BASE_ADDR+0x7000: bits[1:0] R/W, bits[31:2] read 0.
  - DATA at BASE_ADDR+0x5000: 32-bit R/W with WSTRB byte enables.
- mprj_o mapping: [1:0]=CTRL[1:0], [9:2]=DATA[7:0], [35:10]=0, [37:36]=boot status.
- Address decode:
  - addr[31:16]==BASE_ADDR[31:16] is in-window. Offset uses addr[15:0]; addr[1:0] ignored.
  - Unmapped in-window offsets: reads return 0 with OKAY; writes are dropped with OKAY.
  - Out-of-window: DECERR, reads return 0, no state change.
- While periph_aresetn=0, all s_axi ready/valid outputs are 0.

## Timing
- Write channel:
  - awready and wready are high when the write path is idle.
  - AW and W are captured independently, in any order or in the same cycle.
  - The register updates in the cycle after both are captured; bvalid rises in that same cycle.
  - bvalid holds until bready. No new AW/W is accepted until the B handshake completes.
- Read channel:
  - arready is high when idle; rdata/rresp are registered.
  - rvalid rises in the cycle after the AR handshake and holds, with stable data, until rready.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Reset mid-transaction: sys_reset drops all valids/readies to 0 the next cycle and clears registers. resetb_0 does not affect the AXI path or the registers.
- Latency:
  - periph_aresetn rises RST_HOLD_CYCLES+1 cycles after sys_reset falls.
  - READY is reached BOOT_CYCLES + 2 (sync) + 1 cycles after resetb_0 rises with periph_aresetn=1.
- All outputs are 0 during reset, including mprj_o=38'h0.

## Test plan
- Reset release: hold sys_reset=1 for 50 cycles, then 0 -> periph_aresetn=1 exactly 17 cycles later; mprj_o=0.
- Boot: raise resetb_0 after periph_aresetn=1 -> mprj_o[37:36]=2'b11 after 1027 cycles; resetb_0=0 -> mprj_o[37:36]=00 within 3 cycles.
- CTRL readback:
  - read 0x6000_7000 -> 0x0, OKAY.
  - write 0x1, read -> 0x1, mprj_o[1:0]=01.
  - write 0x3, read -> 0x3.
  - write 0xFFFF_FFFF, read -> 0x3.
- DATA readback:
  - read 0x6000_5000 -> 0x0.
  - write 0x11, read -> 0x11, mprj_o[9:2]=0x11.
  - write 0xAABB_CCDD with wstrb=4'b0100, read -> 0x00BB_0011.
- Decode: read 0x7000_0000 -> rresp=11, rdata=0; write there -> bresp=11; read 0x6000_1234 -> OKAY, 0.
- Handshake ordering:
  - W before AW by 3 cycles, bready held low 5 cycles -> single write, bvalid held stable.
  - Same-cycle read and write of CTRL from 0 to 2 -> read returns 0, subsequent read 2.
